// File: rtl/eth_tx_pkg.sv
// Shared constants and FSM encoding for the Ethernet transmit path.
// Build option: FCS_PAD_EN adds the PAD state (short frames zero-padded before the FCS).
package eth_tx_pkg;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

`ifdef FCS_PAD_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_DATA, ST_PAD, ST_FCS, ST_IFG
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_DATA, ST_FCS, ST_IFG
  } state_t;
`endif

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32 (LSB of the byte first).
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_out = (crc_out >> 1) ^ (CRC_POLY_REFL & {32{crc_out[0] ^ data[i]}});
    end
  end

endmodule

// File: rtl/eth_fcs_insert.sv
// Passes preamble/SFD/payload to GMII with one cycle latency, appends the FCS and enforces the IFG.
// Build option: FCS_PAD_EN zero-pads short frames to MIN_DATA bytes before the FCS.
module eth_fcs_insert
  import eth_tx_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_DATA   = 60,
  parameter int CNT_W      = 11
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic       in_en,
  input  logic [7:0] in_data,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       frame_done,
  output logic       frame_drop
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  state_t             state_q, state_d;
  logic [31:0]        crc_q, crc_d, crc_next, fcs;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         fcs_idx_q, fcs_idx_d;
  logic [IFG_W-1:0]   ifg_q, ifg_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         txd_q, txd_d;
  logic               done_q, done_d;
  logic               drop_q, drop_d;
  logic               discard_q, discard_d;
  logic               in_en_q, post_rst_q;
  logic [7:0]         crc_byte, fcs_byte;
  logic               tail, early_win;

  // Pad bytes enter the CRC as zeros; only live data bytes feed the real input.
  assign crc_byte = (state_q == ST_DATA && in_en) ? in_data : 8'h00;
  assign fcs      = crc_q ^ CRC_XOROUT;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    case (fcs_idx_q)
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      crc_q      <= CRC_INIT;
      cnt_q      <= '0;
      fcs_idx_q  <= '0;
      ifg_q      <= '0;
      tx_en_q    <= 1'b0;
      txd_q      <= 8'h00;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      discard_q  <= 1'b0;
      in_en_q    <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      fcs_idx_q  <= fcs_idx_d;
      ifg_q      <= ifg_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      discard_q  <= discard_d;
      in_en_q    <= in_en;
      post_rst_q <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    tail      = 1'b0;
    case (state_q)
      ST_IDLE: if (in_en && !discard_q && !post_rst_q)
                 state_d = (in_data == SFD_BYTE) ? ST_DATA : ST_PRE;
      ST_PRE:  if (!in_en) state_d = ST_IFG;
               else if (in_data == SFD_BYTE) state_d = ST_DATA;
      ST_DATA: if (!in_en) tail = 1'b1;
`ifdef FCS_PAD_EN
      ST_PAD:  tail = 1'b1;
`endif
      ST_FCS:  if (fcs_idx_q == 2'd3) state_d = ST_IFG;
      ST_IFG:  if (ifg_q == IFG_W'(IFG_CYCLES - 1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (tail) begin
`ifdef FCS_PAD_EN
      if (cnt_q < CNT_W'(MIN_DATA)) state_d = ST_PAD;
      else
`endif
      state_d = ST_FCS;
    end
  end

  always_comb begin
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    fcs_idx_d = fcs_idx_q;
    ifg_d     = ifg_q;
    tx_en_d   = 1'b0;
    txd_d     = 8'h00;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    discard_d = discard_q & in_en;
    early_win = (state_q == ST_FCS) || (state_q == ST_IFG);
`ifdef FCS_PAD_EN
    early_win = early_win || (state_q == ST_PAD);
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_en && !discard_q) begin
          if (post_rst_q) begin
            // Tail of a frame cut by reset: treat it like an early frame.
            drop_d    = 1'b1;
            discard_d = 1'b1;
          end else begin
            tx_en_d = 1'b1;
            txd_d   = in_data;
            crc_d   = CRC_INIT;
            cnt_d   = '0;
          end
        end
      end
      ST_PRE: begin
        ifg_d = '0;
        if (in_en) begin
          tx_en_d = 1'b1;
          txd_d   = in_data;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (in_en) begin
          tx_en_d = 1'b1;
          txd_d   = in_data;
          crc_d   = crc_next;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      ST_FCS: begin
        tx_en_d   = 1'b1;
        txd_d     = fcs_byte;
        fcs_idx_d = fcs_idx_q + 2'd1;
        done_d    = (fcs_idx_q == 2'd3);
        ifg_d     = '0;
      end
      ST_IFG:  ifg_d = ifg_q + 1'b1;
      default: ;
    endcase
    // The first FCS byte (or pad byte) leaves on the same edge that sees in_en low.
    if (tail) begin
      tx_en_d = 1'b1;
      if (state_d == ST_FCS) begin
        txd_d     = fcs[7:0];
        fcs_idx_d = 2'd1;
      end else begin
        txd_d = 8'h00;
        crc_d = crc_next;
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (early_win && in_en && !in_en_q && !discard_q) begin
      drop_d    = 1'b1;
      discard_d = 1'b1;
    end
  end

  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign frame_done = done_q;
  assign frame_drop = drop_q;

endmodule

// File: tb/tb_eth_fcs_insert.sv
// Scoreboard bench for eth_fcs_insert: expected GMII cycles are queued as stimulus is driven.
module tb_eth_fcs_insert;

`ifdef FCS_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic       tx_clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_en = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       gmii_tx_en, frame_done, frame_drop;
  logic [7:0] gmii_txd;

  eth_fcs_insert dut (
    .tx_clk     (tx_clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_data    (in_data),
    .gmii_tx_en (gmii_tx_en),
    .gmii_txd   (gmii_txd),
    .frame_done (frame_done),
    .frame_drop (frame_drop)
  );

  always #4 tx_clk = ~tx_clk;

  // Expected cycle: {tx_en, txd, frame_done, frame_drop}
  typedef logic [10:0] exp_t;
  exp_t  sb[$];
  string sb_tag[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge tx_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        t = sb_tag.pop_front();
        check_eq(t, {21'd0, gmii_tx_en, gmii_txd, frame_done, frame_drop}, {21'd0, e});
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [7:0] d, input exp_t x,
                       input string tag);
    @(negedge tx_clk);
    rst     = r;
    in_en   = e;
    in_data = d;
    sb.push_back(x);
    sb_tag.push_back(tag);
  endtask

  function automatic logic [31:0] sw_fcs(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ q[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // Drives one frame and queues the output expected cycle by cycle; returns once the IFG is over.
  task automatic send_frame(input string tag, input int npre, input bit sfd, input logic [7:0] pl[$],
                            input bit fixed_en, input logic [31:0] fixed_fcs,
                            input int burst_at, input int burst_len);
    logic [7:0]  inb[$];
    logic [7:0]  dat[$];
    exp_t        E[$];
    logic [31:0] f;
    int          bs, total;
    logic        ie;
    logic [7:0]  id;
    for (int i = 0; i < npre; i++) inb.push_back(8'h55);
    if (sfd) begin
      inb.push_back(8'hD5);
      foreach (pl[i]) inb.push_back(pl[i]);
    end
    foreach (inb[i]) E.push_back({1'b1, inb[i], 2'b00});
    if (sfd) begin
      dat = pl;
      while (PAD_EN && dat.size() < 60) begin
        dat.push_back(8'h00);
        E.push_back({1'b1, 8'h00, 2'b00});
      end
      f = fixed_en ? fixed_fcs : sw_fcs(dat);
      E.push_back({1'b1, f[7:0], 2'b00});
      E.push_back({1'b1, f[15:8], 2'b00});
      E.push_back({1'b1, f[23:16], 2'b00});
      E.push_back({1'b1, f[31:24], 2'b10});
    end else begin
      E.push_back(11'd0);
    end
    for (int i = 0; i < 12; i++) E.push_back(11'd0);
    bs = E.size() - 12 + burst_at;
    total = E.size();
    if (burst_len > 0) begin
      E[bs] = 11'b1;
      if (bs + burst_len + 1 > total) total = bs + burst_len + 1;
    end
    for (int i = 0; i < total; i++) begin
      ie = 1'b0;
      id = 8'h00;
      if (i < inb.size()) begin
        ie = 1'b1;
        id = inb[i];
      end else if (burst_len > 0 && i >= bs && i < bs + burst_len) begin
        ie = 1'b1;
        id = 8'hA0 + 8'(i);
      end
      drive(1'b0, ie, id, (i < E.size()) ? E[i] : 11'd0, $sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] inb[$];
    logic [7:0] s9[9];
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 11'd0, $sformatf("reset[%0d]", i));
    drive(1'b0, 1'b0, 8'h00, 11'd0, "post_reset");

    pl = {};
    foreach (s9[i]) pl.push_back(s9[i]);
    send_frame("ascii9", 7, 1'b1, pl, !PAD_EN, 32'hCBF43926, 0, 0);

    pl = {};
    send_frame("zero_data", 7, 1'b1, pl, !PAD_EN, 32'h00000000, 0, 0);

    pl = {};
    for (int i = 0; i < 14; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_frame("short14", 7, 1'b1, pl, 1'b0, 32'h0, 0, 0);

    pl = {};
    for (int i = 0; i < 100; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_frame("long100", 7, 1'b1, pl, 1'b0, 32'h0, 0, 0);

    pl = {};
    for (int i = 0; i < 20; i++) pl.push_back(8'(i * 7 + 3));
    send_frame("early_burst", 7, 1'b1, pl, 1'b0, 32'h0, 5, 10);
    pl = {};
    for (int i = 0; i < 30; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_frame("after_burst", 7, 1'b1, pl, 1'b0, 32'h0, 0, 0);

    pl = {};
    send_frame("runt", 7, 1'b0, pl, 1'b0, 32'h0, 0, 0);
    pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    send_frame("after_runt", 7, 1'b1, pl, 1'b0, 32'h0, 0, 0);

    // Reset lands on payload byte 20 while upstream keeps streaming the tail.
    inb = {};
    for (int i = 0; i < 7; i++) inb.push_back(8'h55);
    inb.push_back(8'hD5);
    for (int i = 0; i < 40; i++) inb.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 28; i++)
      drive(1'b0, 1'b1, inb[i], {1'b1, inb[i], 2'b00}, $sformatf("pre_rst[%0d]", i));
    for (int i = 28; i < 31; i++)
      drive(1'b1, 1'b1, inb[i], 11'd0, $sformatf("in_rst[%0d]", i));
    drive(1'b0, 1'b1, inb[31], 11'b1, "rst_tail_drop");
    for (int i = 32; i < 35; i++)
      drive(1'b0, 1'b1, inb[i], 11'd0, $sformatf("rst_tail[%0d]", i));
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 8'h00, 11'd0, $sformatf("rst_gap[%0d]", i));
    pl = {};
    for (int i = 0; i < 25; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_frame("after_rst", 7, 1'b1, pl, 1'b0, 32'h0, 0, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge tx_clk);
    #2;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
